iter_unit_sched: RTL and testbench
==================================

# iter_unit_sched

Sequencer and arbiter for the shared iterative execution unit (multi-cycle divider/multiplier datapath) in the core's execute stage. It grants one of two requesters using round-robin priority, then drives the datapath's start and per-iteration step strobes from an internal step counter. It returns the result handshake with the winning requester's id and tag, and aborts cleanly on pipeline flush.

## Interface
Parameters:
- ITER_CNT, 40: iterations per operation (32 + 8).
- CNT_WIDTH, 6: step counter width; must satisfy 2^CNT_WIDTH >= ITER_CNT.
- TAG_WIDTH, 8: requester-supplied tag width.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-low.
- flush  in  1  pipeline flush; kills any operation in flight.
- req_valid  in  2  request valid, one bit per requester (bit0 = requester 0).
- req_ready  out  2  grant/ready, at most one bit set.
- req_tag  in  2*TAG_WIDTH  tags; requester i uses bits [i*TAG_WIDTH +: TAG_WIDTH].
- dp_early_done  in  1  datapath needs no iterations (e.g. divide-by-zero, trivial operand); sampled in the accept cycle.
- dp_start  out  1  one-cycle strobe: datapath loads operands from requester dp_sel.
- dp_sel  out  1  requester whose operands are loaded or processed.
- dp_step  out  1  advance datapath by one iteration.
- dp_step_idx  out  CNT_WIDTH  current iteration index.
- dp_last  out  1  current step is iteration ITER_CNT-1.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts result.
- resp_id  out  1  requester id of the result.
- resp_tag  out  TAG_WIDTH  tag of the result.
- busy  out  1  state != IDLE.

## Operation
- States:
  - IDLE → BUSY on accept without dp_early_done.
  - IDLE → DONE on accept with dp_early_done.
  - BUSY → DONE on dp_last.
  - DONE → IDLE on resp_valid & resp_ready.
  - Any state → IDLE on flush.
- Accept: req_ready[i] = (state==IDLE) & ~flush & grant[i]; accept = |(req_valid & req_ready).
- Arbitration:
  - Round-robin priority pointer, reset value 0.
  - If both requesters are valid, the one holding the pointer wins; a single valid requester always wins.
  - The pointer moves to the other requester only on accept.
- dp_start = accept (combinational).
  - dp_sel = granted id during the accept cycle; registered id otherwise.
  - resp_id and resp_tag are registered at accept.
- BUSY:
  - dp_step = 1 every cycle; dp_step_idx runs 0..ITER_CNT-1.
  - dp_last = (dp_step_idx == ITER_CNT-1).
  - The counter wraps to 0 on dp_last.
- DONE:
  - resp_valid = ~flush; held, with id and tag stable, until resp_ready.
  - No new request is accepted in DONE.
- Flush:
  - State → IDLE and counter → 0 on the next edge.
  - resp_valid is gated low in the flush cycle, so flush beats a simultaneous resp_ready and no response is delivered.
  - The priority pointer is not changed by flush.
- Reset: state IDLE, counter 0, pointer 0, resp_id 0, resp_tag 0. All outputs are 0 except req_ready, which follows the arbitration equation.

## Timing
- Accept at cycle T → dp_step asserted T+1..T+ITER_CNT → dp_last at T+ITER_CNT → resp_valid from T+ITER_CNT+1.
- Early done: accept at T → resp_valid at T+1 with no dp_step.
- Back-to-back operations: response handshake at cycle R → IDLE at R+1 → next accept possible at R+1.
- Reset asserted mid-operation: all state clears immediately (asynchronous); the first accept is possible in the first cycle after deassertion.

## Structure
- Shared package:
  - State enum (IDLE, BUSY, DONE).
  - Default ITER_CNT and CNT_WIDTH constants, reused by the datapath.
- One sub-module: step_counter.
  - Parameterised wrap counter with clear and enable inputs.
  - Outputs count and end-of-count; clear has priority over enable.
- Arbiter and FSM are inline.

## Test plan
- Single request: req_valid=01, tag 0x5A, resp_ready=1 → dp_start at T, 40 dp_step pulses (idx 0..39), dp_last at T+40, resp_valid at T+41 with id 0, tag 0x5A.
- Contention: req_valid=11 held across three operations → grants alternate 0, 1, 0; req_ready is never 11.
- Backpressure: resp_ready=0 for 10 cycles after resp_valid → resp_valid, id and tag stable; req_ready=00 throughout; IDLE the cycle after resp_ready.
- Flush: flush at step idx 17 → next cycle busy=0, no resp_valid; the following request runs the full 40 steps from idx 0. Flush in DONE together with resp_ready=1 → no response delivered.
- Early done: dp_early_done=1 at accept → no dp_step; resp_valid at T+1.
- Asynchronous reset low during BUSY → busy, resp_valid and dp_step drop without a clock edge; pointer back to 0.

Source files
------------

// File: rtl/iter_unit_sched_pkg.sv
// Shared types and default sizing for the iterative execution unit sequencer and its datapath.
package iter_unit_sched_pkg;

  localparam int ITER_CNT_DEF  = 40;  // 32 quotient/product bits + 8 extra iterations
  localparam int CNT_WIDTH_DEF = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/iter_unit_sched_if.sv
// Request and result handshakes between the two requesters and the unit sequencer.
interface iter_unit_sched_if #(
  parameter int TAG_WIDTH = 8
);
  logic [1:0]             req_valid;
  logic [1:0]             req_ready;
  logic [2*TAG_WIDTH-1:0] req_tag;
  logic                   resp_valid;
  logic                   resp_ready;
  logic                   resp_id;
  logic [TAG_WIDTH-1:0]   resp_tag;

  modport master (
    output req_valid, req_tag, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_tag
  );

  modport slave (
    input  req_valid, req_tag, resp_ready,
    output req_ready, resp_valid, resp_id, resp_tag
  );
endinterface

// File: rtl/iter_unit_sched_step_counter.sv
// Wrap counter for iteration indices; clear beats enable, wraps to 0 after LAST.
module iter_unit_sched_step_counter #(
  parameter int WIDTH = 6,
  parameter int LAST  = 39
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             at_end
);

  localparam logic [WIDTH-1:0] LAST_V = WIDTH'(LAST);

  assign at_end = (count == LAST_V);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= at_end ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/iter_unit_sched.sv
// Round-robin arbiter and step sequencer for the shared multi-cycle divider/multiplier.
module iter_unit_sched
  import iter_unit_sched_pkg::*;
#(
  parameter int ITER_CNT  = ITER_CNT_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF,
  parameter int TAG_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  iter_unit_sched_if.slave     bus,
  input  logic                 dp_early_done,
  output logic                 dp_start,
  output logic                 dp_sel,
  output logic                 dp_step,
  output logic [CNT_WIDTH-1:0] dp_step_idx,
  output logic                 dp_last,
  output logic                 busy
);

  state_t                 state_q, state_d;
  logic                   ptr_q;
  logic                   id_q;
  logic [TAG_WIDTH-1:0]   tag_q;
  logic [1:0]             grant;
  logic                   accept;
  logic                   win_id;
  logic [TAG_WIDTH-1:0]   win_tag;
  logic                   cnt_end;
  logic                   in_idle;

  assign in_idle = (state_q == IDLE);

  // Pointer only breaks ties; a lone requester always wins.
  always_comb begin
    grant = 2'b00;
    unique case (bus.req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  assign bus.req_ready = {2{in_idle & ~flush}} & grant;
  assign accept        = |(bus.req_valid & bus.req_ready);
  assign win_id        = grant[1];
  assign win_tag       = win_id ? bus.req_tag[2*TAG_WIDTH-1:TAG_WIDTH] : bus.req_tag[TAG_WIDTH-1:0];

  iter_unit_sched_step_counter #(
    .WIDTH (CNT_WIDTH),
    .LAST  (ITER_CNT - 1)
  ) u_step_counter (
    .clk    (clk),
    .reset  (reset),
    .clr    (flush),
    .en     (state_q == BUSY),
    .count  (dp_step_idx),
    .at_end (cnt_end)
  );

  assign dp_start       = accept;
  assign dp_sel         = accept ? win_id : id_q;
  assign dp_step        = (state_q == BUSY);
  assign dp_last        = dp_step & cnt_end;
  assign bus.resp_valid = (state_q == DONE) & ~flush;
  assign bus.resp_id    = id_q;
  assign bus.resp_tag   = tag_q;
  assign busy           = ~in_idle;

  // NOTE: the next-state default is assigned first so no path through the case can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = dp_early_done ? DONE : BUSY;
      BUSY:    if (dp_last) state_d = DONE;
      DONE:    if (bus.resp_valid && bus.resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      id_q    <= 1'b0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      // Flush cannot coincide with accept, so the pointer survives a flush untouched.
      if (accept) begin
        ptr_q <= ~win_id;
        id_q  <= win_id;
        tag_q <= win_tag;
      end
    end
  end

endmodule

// File: tb/tb_iter_unit_sched.sv
// Directed bench for iter_unit_sched with a per-cycle reference model and pinned literal checks.
module tb_iter_unit_sched;
  import iter_unit_sched_pkg::*;

  localparam int ITER = 40;
  localparam int CW   = 6;
  localparam int TW   = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          flush = 1'b0;
  logic          dp_early_done = 1'b0;
  logic          dp_start, dp_sel, dp_step, dp_last, busy;
  logic [CW-1:0] dp_step_idx;

  iter_unit_sched_if #(.TAG_WIDTH(TW)) bus ();

  iter_unit_sched #(.ITER_CNT(ITER), .CNT_WIDTH(CW), .TAG_WIDTH(TW)) dut (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .bus           (bus),
    .dp_early_done (dp_early_done),
    .dp_start      (dp_start),
    .dp_sel        (dp_sel),
    .dp_step       (dp_step),
    .dp_step_idx   (dp_step_idx),
    .dp_last       (dp_last),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: m_iter = -1 idle, 0..ITER-1 iteration in progress, ITER result pending.
  int m_iter = -1;
  int m_ptr  = 0;
  int m_id   = 0;
  int m_tag  = 0;

  function automatic int model_win();
    if (bus.req_valid == 2'b11) return m_ptr;
    return bus.req_valid[1] ? 1 : 0;
  endfunction

  function automatic bit model_accept();
    return (m_iter < 0) && !flush && (bus.req_valid != 2'b00);
  endfunction

  function automatic bit model_running();
    return (m_iter >= 0) && (m_iter < ITER);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_iter <= -1;
      m_ptr  <= 0;
      m_id   <= 0;
      m_tag  <= 0;
    end else if (flush) begin
      m_iter <= -1;
    end else if (model_accept()) begin
      m_ptr  <= 1 - model_win();
      m_id   <= model_win();
      m_tag  <= model_win() ? int'(bus.req_tag[15:8]) : int'(bus.req_tag[7:0]);
      m_iter <= dp_early_done ? ITER : 0;
    end else if (model_running()) begin
      m_iter <= m_iter + 1;
    end else if (m_iter == ITER && bus.resp_ready) begin
      m_iter <= -1;
    end
  end

  // Observations of the DUT used by the literal checks in the stimulus.
  int cyc = 0, start_cyc = 0, rv_lat = -1, n_steps = 0, first_idx = -1;
  int hs_count = 0, hs_id = -1, hs_tag = -1;
  bit prev_rv = 1'b0;
  int grants[$];

  always @(negedge clk) begin
    cyc++;
    check("req_ready", bus.req_ready, model_accept() ? (model_win() ? 32'd2 : 32'd1) : 32'd0);
    check("req_ready_onehot", bus.req_ready != 2'b11, 1);
    check("dp_start", dp_start, model_accept());
    check("dp_sel", dp_sel, model_accept() ? model_win() : m_id);
    check("dp_step", dp_step, model_running());
    check("dp_step_idx", dp_step_idx, model_running() ? m_iter : 0);
    check("dp_last", dp_last, m_iter == ITER - 1);
    check("resp_valid", bus.resp_valid, (m_iter == ITER) && !flush);
    check("resp_id", bus.resp_id, m_id);
    check("resp_tag", bus.resp_tag, m_tag);
    check("busy", busy, m_iter >= 0);

    if (dp_start) begin
      start_cyc = cyc;
      n_steps   = 0;
      first_idx = -1;
      grants.push_back(int'(dp_sel));
    end
    if (dp_step) begin
      if (first_idx < 0) first_idx = int'(dp_step_idx);
      n_steps++;
    end
    if (bus.resp_valid && !prev_rv) rv_lat = cyc - start_cyc;
    prev_rv = bus.resp_valid;
    if (bus.resp_valid && bus.resp_ready) begin
      hs_count++;
      hs_id  = int'(bus.resp_id);
      hs_tag = int'(bus.resp_tag);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_hs(input int target);
    int k = 0;
    while (hs_count < target && k < 300) begin tick(); k++; end
    check("wait_handshake", hs_count >= target, 1);
  endtask

  task automatic wait_idx(input int v);
    int k = 0;
    while (!(dp_step && int'(dp_step_idx) == v) && k < 100) begin tick(); k++; end
    check("wait_step_idx", dp_step && int'(dp_step_idx) == v, 1);
  endtask

  task automatic wait_rv();
    int k = 0;
    while (!bus.resp_valid && k < 100) begin tick(); k++; end
    check("wait_resp_valid", bus.resp_valid, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int h;
    bus.req_valid  = 2'b00;
    bus.req_tag    = '0;
    bus.resp_ready = 1'b0;
    tick(2);
    reset = 1'b1;

    // Single request from requester 0.
    bus.req_tag = 16'h005A; bus.req_valid = 2'b01; bus.resp_ready = 1'b1;
    tick();
    bus.req_valid = 2'b00;
    wait_hs(1);
    check("single_steps", n_steps, 40);
    check("single_first_idx", first_idx, 0);
    check("single_latency", rv_lat, 41);
    check("single_id", hs_id, 0);
    check("single_tag", hs_tag, 32'h5A);

    // Contention from a freshly reset pointer.
    reset = 1'b0; tick(); reset = 1'b1;
    grants.delete();
    bus.req_tag = 16'h2211; bus.req_valid = 2'b11;
    h = hs_count;
    wait_hs(h + 3);
    bus.req_valid = 2'b00;
    check("rr_count", grants.size(), 3);
    if (grants.size() == 3) begin
      check("rr_grant0", grants[0], 0);
      check("rr_grant1", grants[1], 1);
      check("rr_grant2", grants[2], 0);
    end
    check("rr_last_tag", hs_tag, 32'h11);

    // Backpressure, with requester 1 waiting during DONE.
    bus.resp_ready = 1'b0; bus.req_tag = 16'h8877; bus.req_valid = 2'b01;
    tick();
    bus.req_valid = 2'b10;
    wait_rv();
    repeat (10) begin
      check("bp_resp_valid", bus.resp_valid, 1);
      check("bp_resp_tag", bus.resp_tag, 32'h77);
      check("bp_resp_id", bus.resp_id, 0);
      check("bp_req_ready", bus.req_ready, 0);
      tick();
    end
    bus.resp_ready = 1'b1;
    h = hs_count;
    tick();
    check("bp_handshake", hs_count, h + 1);
    check("bp_idle_after", busy, 0);
    bus.req_valid = 2'b00;

    // Flush mid-operation, then a full-length operation from requester 1.
    bus.req_tag = 16'h4433; bus.req_valid = 2'b01;
    tick();
    bus.req_valid = 2'b00;
    wait_idx(17);
    flush = 1'b1;
    h = hs_count;
    tick();
    flush = 1'b0;
    check("flush_busy", busy, 0);
    check("flush_resp_valid", bus.resp_valid, 0);
    bus.req_valid = 2'b11;
    tick();
    bus.req_valid = 2'b00;
    wait_hs(h + 1);
    check("post_flush_steps", n_steps, 40);
    check("post_flush_first_idx", first_idx, 0);
    check("post_flush_id", hs_id, 1);
    check("post_flush_tag", hs_tag, 32'h44);

    // Flush in DONE racing resp_ready.
    bus.resp_ready = 1'b0; bus.req_tag = 16'h4455; bus.req_valid = 2'b01;
    tick();
    bus.req_valid = 2'b00;
    wait_rv();
    h = hs_count;
    flush = 1'b1; bus.resp_ready = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_done_no_resp", hs_count, h);
    check("flush_done_busy", busy, 0);
    tick(2);
    check("flush_done_still_none", hs_count, h);

    // Early done.
    bus.req_tag = 16'h0066; bus.req_valid = 2'b01; dp_early_done = 1'b1;
    tick();
    dp_early_done = 1'b0; bus.req_valid = 2'b00;
    h = hs_count;
    wait_hs(h + 1);
    check("early_steps", n_steps, 0);
    check("early_latency", rv_lat, 1);
    check("early_tag", hs_tag, 32'h66);

    // Asynchronous reset during BUSY; requester 0 won last, so the pointer sits at 1.
    bus.req_tag = 16'h0099; bus.req_valid = 2'b01;
    tick();
    bus.req_valid = 2'b00;
    wait_idx(5);
    #2 reset = 1'b0;
    #1;
    check("async_busy", busy, 0);
    check("async_resp_valid", bus.resp_valid, 0);
    check("async_dp_step", dp_step, 0);
    check("async_idx", dp_step_idx, 0);
    tick();
    bus.req_tag = 16'hBBAA; bus.req_valid = 2'b11;
    reset = 1'b1;
    #1;
    check("post_reset_grant", bus.req_ready, 2'b01);
    h = hs_count;
    tick();
    bus.req_valid = 2'b00;
    wait_hs(h + 1);
    check("post_reset_id", hs_id, 0);
    check("post_reset_tag", hs_tag, 32'hAA);

    tick(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
